// File: rtl/tick_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module : tick_pwm_pkg
// Brief  : Shared state encodings and constants for the tick-driven PWM.
// Rev    : 1.0  initial release
// ============================================================================
package tick_pwm_pkg;

  typedef enum logic [0:0] {
    TICK_PWM_IDLE = 1'b0,
    TICK_PWM_RUN  = 1'b1
  } tick_pwm_state_t;

  localparam int CFG_PERIOD_STOP = 0;

endpackage
`default_nettype wire

// File: rtl/cfg_shadow_reg.sv
`default_nettype none
// ============================================================================
// Module : cfg_shadow_reg
// Brief  : One-entry valid/ready holding register, emptied by the consumer.
// Rev    : 1.0  initial release
// ============================================================================
module cfg_shadow_reg #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_consume,
  output logic              o_full,
  output logic [DATA_W-1:0] o_data
);

  logic              r_full;
  logic [DATA_W-1:0] r_data;
  logic              w_accept;

  assign w_accept = i_valid && !r_full;
  assign o_ready  = !r_full;
  assign o_full   = r_full;
  assign o_data   = r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_consume) begin
      r_full <= 1'b0;
    end else if (w_accept) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tick_pwm.sv
`default_nettype none
// ============================================================================
// Module : tick_pwm
// Brief  : Tick-driven PWM with shadowed period/duty applied on boundaries.
// Rev    : 1.0  initial release
// ============================================================================
module tick_pwm
  import tick_pwm_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit INVERT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_duty,
  output logic             pwm_out,
  output logic             cycle_start,
  output logic             busy
);

  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_stop = WIDTH'(CFG_PERIOD_STOP);

  tick_pwm_state_t  r_state;
  logic [WIDTH-1:0] r_phase;
  logic [WIDTH-1:0] r_active_period;
  logic [WIDTH-1:0] r_active_duty;
  logic             r_pwm;
  logic             r_cycle_start;
  logic             r_busy;

  logic             w_full;
  logic [WIDTH-1:0] w_sh_period;
  logic [WIDTH-1:0] w_sh_duty;
  logic             w_boundary;
  logic             w_consume;
  logic [WIDTH-1:0] w_phase_inc;

  cfg_shadow_reg #(
    .DATA_W (2*WIDTH)
  ) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (cfg_valid),
    .o_ready   (cfg_ready),
    .i_data    ({cfg_period, cfg_duty}),
    .i_consume (w_consume),
    .o_full    (w_full),
    .o_data    ({w_sh_period, w_sh_duty})
  );

  // The shadow is drained either when leaving IDLE or at a RUN boundary.
  assign w_boundary  = (r_state == TICK_PWM_RUN) && tick &&
                       (r_phase == r_active_period - c_one);
  assign w_consume   = tick && w_full && ((r_state == TICK_PWM_IDLE) || w_boundary);
  assign w_phase_inc = r_phase + c_one;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= TICK_PWM_IDLE;
      r_phase         <= '0;
      r_active_period <= '0;
      r_active_duty   <= '0;
      r_pwm           <= INVERT;
      r_cycle_start   <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_cycle_start <= 1'b0;
      if (tick) begin
        case (r_state)
          TICK_PWM_IDLE: begin
            if (w_full && (w_sh_period != c_stop)) begin
              r_active_period <= w_sh_period;
              r_active_duty   <= w_sh_duty;
              r_phase         <= '0;
              r_state         <= TICK_PWM_RUN;
              r_busy          <= 1'b1;
              r_pwm           <= ('0 < w_sh_duty) ^ INVERT;
            end
          end
          TICK_PWM_RUN: begin
            if (w_boundary) begin
              r_phase <= '0;
              if (w_full && (w_sh_period == c_stop)) begin
                r_state <= TICK_PWM_IDLE;
                r_busy  <= 1'b0;
                r_pwm   <= INVERT;
              end else if (w_full) begin
                r_cycle_start   <= 1'b1;
                r_active_period <= w_sh_period;
                r_active_duty   <= w_sh_duty;
                r_pwm           <= ('0 < w_sh_duty) ^ INVERT;
              end else begin
                r_cycle_start <= 1'b1;
                r_pwm         <= ('0 < r_active_duty) ^ INVERT;
              end
            end else begin
              r_phase <= w_phase_inc;
              r_pwm   <= (w_phase_inc < r_active_duty) ^ INVERT;
            end
          end
          default: begin
            r_state <= TICK_PWM_IDLE;
            r_busy  <= 1'b0;
            r_phase <= '0;
            r_pwm   <= INVERT;
          end
        endcase
      end
    end
  end

  assign pwm_out     = r_pwm;
  assign cycle_start = r_cycle_start;
  assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_tick_pwm.sv
`default_nettype none
// ============================================================================
// Module : tb_tick_pwm
// Brief  : Scoreboard bench for tick_pwm (WIDTH=8, INVERT=0).
// Rev    : 1.0  initial release
// ============================================================================
module tb_tick_pwm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_period = '0;
  logic [7:0] cfg_duty = '0;
  logic       cfg_ready;
  logic       pwm_out;
  logic       cycle_start;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic pwm;
    logic cs;
    logic bsy;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  tick_pwm #(
    .WIDTH  (8),
    .INVERT (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_period  (cfg_period),
    .cfg_duty    (cfg_duty),
    .pwm_out     (pwm_out),
    .cycle_start (cycle_start),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every tick the DUT samples yields one output update 1 clk later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (tick && rst) begin
        #1;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL scoreboard: tick with no expected entry at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("pwm_out", pwm_out, e.pwm);
          chk("cycle_start", cycle_start, e.cs);
          chk("busy", busy, e.bsy);
        end
      end
    end
  end

  // Issue n ticks; bit i of each vector is the expectation after tick i.
  task automatic run_ticks(input int n, input logic [15:0] pwm_v,
                           input logic [15:0] cs_v, input logic [15:0] busy_v,
                           input int gap);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      exp_q.push_back('{pwm: pwm_v[i], cs: cs_v[i], bsy: busy_v[i]});
      @(negedge clk);
      if (gap > 0) begin
        tick = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    tick = 1'b0;
  endtask

  task automatic send_cfg(input logic [7:0] p, input logic [7:0] d);
    int w = 0;
    while (!cfg_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!cfg_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL cfg_wait: cfg_ready got 0 expected 1 within 50 clk");
    end
    cfg_valid  = 1'b1;
    cfg_period = p;
    cfg_duty   = d;
    @(negedge clk);
    cfg_valid  = 1'b0;
  endtask

  // Tick and config offered on the same edge as a boundary.
  task automatic race_tick_cfg(input logic [7:0] p, input logic [7:0] d,
                               input exp_t e);
    chk("race_ready", cfg_ready, 1'b1);
    tick       = 1'b1;
    cfg_valid  = 1'b1;
    cfg_period = p;
    cfg_duty   = d;
    exp_q.push_back(e);
    @(negedge clk);
    tick      = 1'b0;
    cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2;
    chk("rst_pwm", pwm_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cs", cycle_start, 1'b0);
    chk("rst_ready", cfg_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic 5/2
    send_cfg(8'd5, 8'd2);
    chk("ready_full", cfg_ready, 1'b0);
    run_ticks(1, 16'h0001, 16'h0000, 16'h0001, 2);
    chk("ready_after_load", cfg_ready, 1'b1);
    run_ticks(9, 16'h0031, 16'h0010, 16'h01FF, 2);

    // Update to 4/3 sent at phase 1; old cycle completes first
    run_ticks(2, 16'h0003, 16'h0001, 16'h0003, 2);
    send_cfg(8'd4, 8'd3);
    chk("ready_held_0", cfg_ready, 1'b0);
    run_ticks(3, 16'h0000, 16'h0000, 16'h0007, 2);
    chk("ready_held_1", cfg_ready, 1'b0);
    run_ticks(4, 16'h0007, 16'h0001, 16'h000F, 2);
    chk("ready_after_apply", cfg_ready, 1'b1);

    // Race: accept on the boundary edge, old 4/3 repeats once
    race_tick_cfg(8'd5, 8'd2, '{pwm: 1'b1, cs: 1'b1, bsy: 1'b1});
    run_ticks(3, 16'h0003, 16'h0000, 16'h0007, 2);
    chk("race_no_bypass", cfg_ready, 1'b0);
    run_ticks(5, 16'h0003, 16'h0001, 16'h001F, 2);

    // duty = 0
    send_cfg(8'd5, 8'd0);
    run_ticks(5, 16'h0000, 16'h0001, 16'h001F, 2);
    // duty >= period
    send_cfg(8'd5, 8'd9);
    run_ticks(5, 16'h001F, 16'h0001, 16'h001F, 2);
    // stop request
    send_cfg(8'd0, 8'd0);
    run_ticks(3, 16'h0000, 16'h0000, 16'h0000, 2);
    chk("ready_after_stop", cfg_ready, 1'b1);

    // period = 1 with back-to-back ticks
    send_cfg(8'd1, 8'd1);
    run_ticks(6, 16'h003F, 16'h003E, 16'h003F, 0);
    chk("pre_rst_pwm", pwm_out, 1'b1);

    // Asynchronous reset mid-RUN, away from any clock edge
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_pwm", pwm_out, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_ready", cfg_ready, 1'b1);
    chk("async_rst_cs", cycle_start, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("scoreboard_empty", exp_q.size() == 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
